apb_rr_arbiter: RTL and testbench

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

---
 rtl/apb_rr_arbiter_pkg.sv | 27 ++
 rtl/apb_rr_arbiter_if.sv | 44 ++++
 rtl/apb_rr_arbiter_pick.sv | 36 +++
 rtl/apb_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_rr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_rr_arbiter_pkg                                           |
// | Description : Shared SoC config for the APB round-robin arbiter: FSM       |
// |               state encodings, timeout error data and a one-hot helper.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package apb_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } arb_state_e;

    localparam int c_MAX_PORTS      = 16;
    localparam int c_MAX_DATA_WIDTH = 64;

    // Read data returned to a master whose transfer was aborted; sliced to DATA_WIDTH.
    localparam logic [c_MAX_DATA_WIDTH-1:0] c_TIMEOUT_RDATA = '1;

    function automatic logic [c_MAX_PORTS-1:0] idx_to_onehot(input logic [3:0] idx);
        return {{(c_MAX_PORTS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_rr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_rr_arbiter_if                                            |
// | Description : Bundled per-master APB request ports and the shared          |
// |               downstream APB port. 'master' is the arbiter's view,         |
// |               'slave' is the surrounding system's view.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface apb_rr_arbiter_if #(
    parameter int MASTER_PORTS = 4,
    parameter int BUS_WIDTH    = 16,
    parameter int DATA_WIDTH   = 16
);
    logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR;
    logic [MASTER_PORTS-1:0]            S_PWRITE;
    logic [MASTER_PORTS-1:0]            S_PSELx;
    logic [MASTER_PORTS-1:0]            S_PENABLE;
    logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA;
    logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA;
    logic [MASTER_PORTS-1:0]            S_PREADY;

    logic [BUS_WIDTH-1:0]               M_PADDR;
    logic                               M_PWRITE;
    logic                               M_PSEL;
    logic                               M_PENABLE;
    logic [DATA_WIDTH-1:0]              M_PWDATA;
    logic [DATA_WIDTH-1:0]              M_PRDATA;
    logic                               M_PREADY;

    modport master (
        input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
        output S_PRDATA, S_PREADY,
        output M_PADDR, M_PWRITE, M_PSEL, M_PENABLE, M_PWDATA,
        input  M_PRDATA, M_PREADY
    );

    modport slave (
        output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
        input  S_PRDATA, S_PREADY,
        input  M_PADDR, M_PWRITE, M_PSEL, M_PENABLE, M_PWDATA,
        output M_PRDATA, M_PREADY
    );
endinterface
`default_nettype wire

// File: rtl/apb_rr_arbiter_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_rr_pick                                                  |
// | Description : Combinational round-robin selector: first requester found    |
// |               searching upward from (last+1) mod MASTER_PORTS.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module apb_rr_pick #(
    parameter int MASTER_PORTS = 4,
    parameter int IDX_W        = $clog2(MASTER_PORTS)
) (
    input  wire  [MASTER_PORTS-1:0] i_req,
    input  wire  [IDX_W-1:0]        i_last,
    output logic                    o_valid,
    output logic [IDX_W-1:0]        o_idx
);
    int w_cand;

    // Walk offsets from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int k = MASTER_PORTS; k >= 1; k--) begin
            w_cand = int'(i_last) + k;
            if (w_cand >= MASTER_PORTS) begin
                w_cand = w_cand - MASTER_PORTS;
            end
            if (i_req[w_cand[IDX_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_rr_arbiter                                               |
// | Description : Round-robin arbiter funnelling N APB masters onto one        |
// |               downstream APB port. Optional ACCESS timeout is compiled in  |
// |               with macro APB_ARB_TIMEOUT_EN.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module apb_rr_arbiter
    import apb_rr_arbiter_pkg::*;
#(
    parameter int MASTER_PORTS   = 4,
    parameter int BUS_WIDTH      = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire                     clk,
    input  wire                     reset,
    apb_rr_arbiter_if.master        bus,
    output logic [MASTER_PORTS-1:0] grant,
    output logic                    timeout
);
    localparam int c_IDX_W = $clog2(MASTER_PORTS);

    arb_state_e              state_q, state_d;
    logic [c_IDX_W-1:0]      last_q, last_d;
    logic [MASTER_PORTS-1:0] grant_q, grant_d;
    logic [BUS_WIDTH-1:0]    m_paddr_q, m_paddr_d;
    logic                    m_pwrite_q, m_pwrite_d;
    logic                    m_psel_q, m_psel_d;
    logic                    m_penable_q, m_penable_d;
    logic [DATA_WIDTH-1:0]   m_pwdata_q, m_pwdata_d;

    logic                    w_pick_valid;
    logic [c_IDX_W-1:0]      w_pick_idx;
    logic [c_MAX_PORTS-1:0]  w_pick_onehot;
    logic                    w_abort;
    logic                    w_complete;
    logic                    w_unused_penable;

    apb_rr_pick #(
        .MASTER_PORTS (MASTER_PORTS),
        .IDX_W        (c_IDX_W)
    ) u_pick (
        .i_req   (bus.S_PSELx),
        .i_last  (last_q),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_pick_onehot    = idx_to_onehot(4'(w_pick_idx));
    assign w_unused_penable = ^bus.S_PENABLE;

`ifdef APB_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    assign w_abort = (state_q == ST_ACCESS) && !bus.M_PREADY &&
                     (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == ST_ACCESS) && !bus.M_PREADY && !w_abort) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    wire [15:0] w_unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
    assign w_abort = 1'b0;
`endif

    assign w_complete = (state_q == ST_ACCESS) && (bus.M_PREADY || w_abort);
    assign timeout    = w_abort;

    // The owner is always last_q while a transfer is in flight.
    always_comb begin
        bus.S_PREADY = '0;
        bus.S_PRDATA = '0;
        if (w_complete) begin
            bus.S_PREADY[last_q] = 1'b1;
            bus.S_PRDATA[last_q*DATA_WIDTH +: DATA_WIDTH] =
                w_abort ? c_TIMEOUT_RDATA[DATA_WIDTH-1:0] : bus.M_PRDATA;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        m_paddr_d   = m_paddr_q;
        m_pwrite_d  = m_pwrite_q;
        m_psel_d    = m_psel_q;
        m_penable_d = m_penable_q;
        m_pwdata_d  = m_pwdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    m_paddr_d   = bus.S_PADDR[w_pick_idx*BUS_WIDTH +: BUS_WIDTH];
                    m_pwrite_d  = bus.S_PWRITE[w_pick_idx];
                    m_pwdata_d  = bus.S_PWDATA[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    grant_d     = w_pick_onehot[MASTER_PORTS-1:0];
                    last_d      = w_pick_idx;
                    m_psel_d    = 1'b1;
                    m_penable_d = 1'b0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                m_penable_d = 1'b1;
                state_d     = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_complete) begin
                    m_psel_d    = 1'b0;
                    m_penable_d = 1'b0;
                    grant_d     = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                m_psel_d    = 1'b0;
                m_penable_d = 1'b0;
                grant_d     = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // last resets to the top index so master 0 is searched first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= c_IDX_W'(MASTER_PORTS - 1);
            grant_q     <= '0;
            m_paddr_q   <= '0;
            m_pwrite_q  <= 1'b0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_pwdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            m_paddr_q   <= m_paddr_d;
            m_pwrite_q  <= m_pwrite_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            m_pwdata_q  <= m_pwdata_d;
        end
    end

    assign bus.M_PADDR   = m_paddr_q;
    assign bus.M_PWRITE  = m_pwrite_q;
    assign bus.M_PSEL    = m_psel_q;
    assign bus.M_PENABLE = m_penable_q;
    assign bus.M_PWDATA  = m_pwdata_q;
    assign grant         = grant_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_apb_rr_arbiter                                            |
// | Description : Directed, table-driven bench for apb_rr_arbiter; exercises   |
// |               the timeout path when APB_ARB_TIMEOUT_EN is defined.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_apb_rr_arbiter;
    localparam int MP = 4;
    localparam int BW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [MP-1:0] grant;
    logic          timeout;

    always #5 clk = ~clk;

    apb_rr_arbiter_if #(.MASTER_PORTS(MP), .BUS_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

    apb_rr_arbiter #(
        .MASTER_PORTS   (MP),
        .BUS_WIDTH      (BW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.master),
        .grant   (grant),
        .timeout (timeout)
    );

    logic [BW-1:0] addr_tab  [MP] = '{16'h0100, 16'h0204, 16'h0012, 16'h3FFC};
    logic [DW-1:0] wdata_tab [MP] = '{16'h1111, 16'h2222, 16'hBEEF, 16'h4444};

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [MP-1:0] req;
        logic          wr;
        int            waits;
        logic [DW-1:0] rdata;
        int            exp_idx;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One full transfer starting in IDLE; requests stay asserted afterwards.
    task automatic run_txn(input logic [MP-1:0] req, input logic wr, input int waits,
                           input logic [DW-1:0] rdata, input int exp_idx);
        logic [MP-1:0]    oh;
        logic [MP*DW-1:0] exp_prd;
        oh      = MP'(1) << exp_idx;
        exp_prd = (MP*DW)'(rdata) << (exp_idx * DW);
        bus.S_PSELx  = req;
        bus.S_PWRITE = {MP{wr}};
        bus.M_PRDATA = rdata;
        bus.M_PREADY = 1'b0;
        #1;
        chk("idle_grant", grant, '0);
        chk("idle_psel", bus.M_PSEL, 1'b0);
        @(posedge clk); #1;
        chk("setup_grant", grant, oh);
        chk("setup_psel", bus.M_PSEL, 1'b1);
        chk("setup_penable", bus.M_PENABLE, 1'b0);
        chk("setup_paddr", bus.M_PADDR, addr_tab[exp_idx]);
        chk("setup_pwrite", bus.M_PWRITE, wr);
        chk("setup_pwdata", bus.M_PWDATA, wdata_tab[exp_idx]);
        chk("setup_spready", bus.S_PREADY, '0);
        @(posedge clk); #1;
        chk("access_penable", bus.M_PENABLE, 1'b1);
        for (int w = 0; w < waits; w++) begin
            chk("wait_spready", bus.S_PREADY, '0);
            chk("wait_psel", bus.M_PSEL, 1'b1);
            chk("wait_paddr", bus.M_PADDR, addr_tab[exp_idx]);
            chk("wait_pwdata", bus.M_PWDATA, wdata_tab[exp_idx]);
            chk("wait_grant", grant, oh);
            @(posedge clk); #1;
        end
        bus.M_PREADY = 1'b1;
        #1;
        chk("done_spready", bus.S_PREADY, oh);
        chk("done_sprdata", bus.S_PRDATA, exp_prd);
        chk("done_pwdata", bus.M_PWDATA, wdata_tab[exp_idx]);
        @(posedge clk); #1;
        bus.M_PREADY = 1'b0;
        chk("end_psel", bus.M_PSEL, 1'b0);
        chk("end_penable", bus.M_PENABLE, 1'b0);
        chk("end_grant", grant, '0);
        chk("end_spready", bus.S_PREADY, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'b1111, 1'b1, 0, 16'h0000, 0};
        vecs[1]  = '{4'b1111, 1'b1, 0, 16'h0000, 1};
        vecs[2]  = '{4'b1111, 1'b0, 0, 16'h0C0C, 2};
        vecs[3]  = '{4'b1111, 1'b1, 1, 16'h0000, 3};
        vecs[4]  = '{4'b1111, 1'b0, 0, 16'h7777, 0};
        vecs[5]  = '{4'b0101, 1'b0, 3, 16'h1234, 2};
        vecs[6]  = '{4'b0101, 1'b1, 0, 16'h0000, 0};
        vecs[7]  = '{4'b1000, 1'b0, 2, 16'h8001, 3};
        vecs[8]  = '{4'b0011, 1'b1, 0, 16'h0000, 0};
        vecs[9]  = '{4'b0010, 1'b0, 0, 16'h00AA, 1};
        vecs[10] = '{4'b0010, 1'b1, 0, 16'h0000, 1};
        vecs[11] = '{4'b1010, 1'b0, 2, 16'hA5A5, 3};
        vecs[12] = '{4'b0110, 1'b1, 0, 16'h0000, 1};

        reset         = 1'b1;
        bus.S_PSELx   = '0;
        bus.S_PWRITE  = '0;
        bus.S_PENABLE = '1;
        bus.S_PADDR   = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        bus.S_PWDATA  = {wdata_tab[3], wdata_tab[2], wdata_tab[1], wdata_tab[0]};
        bus.M_PRDATA  = '0;
        bus.M_PREADY  = 1'b0;
        #1;
        chk("rst_psel", bus.M_PSEL, 1'b0);
        chk("rst_grant", grant, '0);
        chk("rst_timeout", timeout, 1'b0);
        do_reset();

        // Single write from master 2, zero-wait slave.
        run_txn(4'b0100, 1'b1, 0, 16'h0000, 2);
        bus.S_PSELx = '0;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].req, vecs[i].wr, vecs[i].waits, vecs[i].rdata, vecs[i].exp_idx);
        end

        // Owner drops its request mid-transfer while others start requesting.
        bus.S_PSELx  = 4'b0001;
        bus.M_PRDATA = 16'h5A5A;
        @(posedge clk); #1;
        chk("mid_setup_grant", grant, 4'b0001);
        bus.S_PSELx = 4'b1110;
        @(posedge clk); #1;
        chk("mid_access_grant", grant, 4'b0001);
        @(posedge clk); #1;
        chk("mid_wait_spready", bus.S_PREADY, '0);
        chk("mid_wait_psel", bus.M_PSEL, 1'b1);
        bus.M_PREADY = 1'b1;
        #1;
        chk("mid_done_spready", bus.S_PREADY, 4'b0001);
        chk("mid_done_sprdata", bus.S_PRDATA, 64'h5A5A);
        @(posedge clk); #1;
        bus.M_PREADY = 1'b0;
        @(posedge clk); #1;
        chk("mid_next_grant", grant, 4'b0010);
        @(posedge clk); #1;
        bus.M_PREADY = 1'b1;
        @(posedge clk); #1;
        bus.M_PREADY = 1'b0;
        bus.S_PSELx  = '0;
        chk("mid_end_grant", grant, '0);

        // Asynchronous reset during ACCESS.
        bus.S_PSELx = 4'b1111;
        @(posedge clk); #1;
        chk("rstacc_setup_grant", grant, 4'b0100);
        @(posedge clk); #2;
        chk("rstacc_penable", bus.M_PENABLE, 1'b1);
        reset = 1'b1;
        #1;
        chk("rstacc_psel", bus.M_PSEL, 1'b0);
        chk("rstacc_penable0", bus.M_PENABLE, 1'b0);
        chk("rstacc_paddr", bus.M_PADDR, '0);
        chk("rstacc_pwdata", bus.M_PWDATA, '0);
        chk("rstacc_pwrite", bus.M_PWRITE, 1'b0);
        chk("rstacc_grant", grant, '0);
        chk("rstacc_timeout", timeout, 1'b0);
        chk("rstacc_spready", bus.S_PREADY, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_txn(4'b1111, 1'b0, 0, 16'h0F0F, 0);

        // Slave never responds.
        bus.S_PSELx  = 4'b0110;
        bus.M_PREADY = 1'b0;
        @(posedge clk); #1;
        chk("stuck_setup_grant", grant, 4'b0010);
        @(posedge clk); #1;
`ifdef APB_ARB_TIMEOUT_EN
        for (int k = 1; k < TO; k++) begin
            chk("tmo_early_timeout", timeout, 1'b0);
            chk("tmo_early_spready", bus.S_PREADY, '0);
            @(posedge clk); #1;
        end
        chk("tmo_pulse", timeout, 1'b1);
        chk("tmo_spready", bus.S_PREADY, 4'b0010);
        chk("tmo_sprdata", bus.S_PRDATA, 64'hFFFF_0000);
        @(posedge clk); #1;
        chk("tmo_pulse_end", timeout, 1'b0);
        chk("tmo_psel", bus.M_PSEL, 1'b0);
        chk("tmo_grant", grant, '0);
`else
        for (int k = 0; k < 20; k++) begin
            chk("stuck_timeout", timeout, 1'b0);
            chk("stuck_spready", bus.S_PREADY, '0);
            chk("stuck_psel", bus.M_PSEL, 1'b1);
            @(posedge clk); #1;
        end
        bus.M_PREADY = 1'b1;
        #1;
        chk("stuck_release_spready", bus.S_PREADY, 4'b0010);
        @(posedge clk); #1;
        bus.M_PREADY = 1'b0;
`endif
        run_txn(4'b0110, 1'b0, 0, 16'h0055, 2);
        bus.S_PSELx = '0;
        @(posedge clk); #1;
        chk("final_grant", grant, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
